// File: rtl/serial_pkg.sv
// Shared definitions for the serial feeder and the downstream 101 detector.
package serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic IDLE_LEVEL = 1'b0;

    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder: accepts a word on a valid/ready handshake and
// shifts it out one bit per clock, chaining back-to-back words with no gap.
module bit_serializer
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned    CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    r_cnt;
    logic             r_out;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_done;
    logic             r_load_ready;

    logic             w_accept;
    logic             w_last;
    logic             w_first_bit;
    logic             w_next_bit;
    logic             w_next_last;
    logic [WIDTH-1:0] w_load_sr;
    logic [WIDTH-1:0] w_shift_sr;
    logic [CW-1:0]    w_cnt_inc;

    assign w_accept    = load_valid && r_load_ready;
    assign w_last      = (r_state == SHIFT) && (r_cnt == LAST);
    assign w_cnt_inc   = r_cnt + CW'(1);
    assign w_next_last = (w_cnt_inc == LAST);

    // sr always holds the bits still to be sent, next one at the shift-out end
    assign w_first_bit = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
    assign w_load_sr   = MSB_FIRST ? (data_in << 1) : (data_in >> 1);
    assign w_next_bit  = MSB_FIRST ? r_sr[WIDTH-1] : r_sr[0];
    assign w_shift_sr  = MSB_FIRST ? (r_sr << 1) : (r_sr >> 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_sr         <= '0;
            r_cnt        <= '0;
            r_out        <= IDLE_LEVEL;
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_load_ready <= 1'b1;
        end else if (w_accept) begin
            // accept from IDLE or on the closing edge of the last bit
            r_state      <= SHIFT;
            r_sr         <= w_load_sr;
            r_cnt        <= '0;
            r_out        <= w_first_bit;
            r_out_valid  <= 1'b1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_load_ready <= 1'b0;
        end else if (r_state == SHIFT) begin
            if (w_last) begin
                r_state      <= IDLE;
                r_cnt        <= '0;
                r_out        <= IDLE_LEVEL;
                r_out_valid  <= 1'b0;
                r_busy       <= 1'b0;
                r_done       <= 1'b0;
                r_load_ready <= 1'b1;
            end else begin
                r_sr         <= w_shift_sr;
                r_cnt        <= w_cnt_inc;
                r_out        <= w_next_bit;
                r_done       <= w_next_last;
                r_load_ready <= w_next_last;
            end
        end
    end

    assign load_ready = r_load_ready;
    assign out        = r_out;
    assign out_valid  = r_out_valid;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
